// File: rtl/ins_enc_pkg.sv
// Shared types and constants for the RV32IM instruction encoder.
// Format tags, the encoded word bundle and the output storage states.
package ins_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } enc_fmt_t;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] ins;
    logic        err;
  } enc_word_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } store_state_t;

  // True when v[31:lsb] are all copies of the sign bit, i.e. v fits as a
  // signed value of lsb+1 bits.
  function automatic logic upper_uniform(input logic [31:0] v, input logic [4:0] lsb);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (b >= int'(lsb) && v[b] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ins_pack.sv
// Combinational field packer: decoded fields + format tag -> instruction word.
// Define ENC_RANGE_CHECK_EN to also flag immediates that do not fit the format.
module ins_pack
  import ins_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output enc_word_t   word_o
);

  logic [31:0] ins_raw;
  logic        fmt_bad;
  logic        range_bad;

  always_comb begin
    ins_raw = NOP_INS;
    fmt_bad = 1'b0;
    case (fmt_i)
      FMT_R: ins_raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: ins_raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: ins_raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: ins_raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: ins_raw = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: ins_raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                        rd_i, opcode_i};
      default: begin
        ins_raw = NOP_INS;
        fmt_bad = 1'b1;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Word is still built from truncated bits; only the error flag reflects overflow.
  always_comb begin
    range_bad = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: range_bad = !upper_uniform(imm_i, 5'd11);
      FMT_B:        range_bad = imm_i[0] || !upper_uniform(imm_i, 5'd12);
      FMT_J:        range_bad = imm_i[0] || !upper_uniform(imm_i, 5'd20);
      FMT_U:        range_bad = (imm_i[11:0] != 12'd0);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  // Without the range check the branch/jump offset LSB never reaches the word.
  logic unused_imm_bit;
  assign unused_imm_bit = imm_i[0];
  assign range_bad      = 1'b0;
`endif

  assign word_o.ins = ins_raw;
  assign word_o.err = fmt_bad | range_bad;

endmodule

// File: rtl/ins_encoder.sv
// Streaming RV32IM instruction encoder: valid/ready in and out, registered
// output stage plus one skid entry so back-pressure costs no throughput.
module ins_encoder
  import ins_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      ins,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  store_state_t     state_q, state_d;
  enc_word_t        out_q, skid_q;
  enc_word_t        new_word;
  logic [CNT_W-1:0] cnt_q;

  logic load_out_new;
  logic load_out_skid;
  logic load_skid;
  logic count_en;

  ins_pack u_pack (
    .fmt_i    (fmt),
    .opcode_i (opcode),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .imm_i    (imm),
    .word_o   (new_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready is decoded from state only, so in_valid alone decides an accept
  // outside ST_TWO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_valid) state_d = ST_ONE;
      ST_ONE: begin
        if (in_valid && !out_ready)      state_d = ST_TWO;
        else if (!in_valid && out_ready) state_d = ST_EMPTY;
      end
      ST_TWO:   if (out_ready) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready      = 1'b1;
    out_valid     = 1'b0;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        load_out_new = in_valid;
      end
      ST_ONE: begin
        out_valid    = 1'b1;
        load_out_new = in_valid && out_ready;
        load_skid    = in_valid && !out_ready;
      end
      ST_TWO: begin
        in_ready      = 1'b0;
        out_valid     = 1'b1;
        load_out_skid = out_ready;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
    count_en = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_out_new) begin
        out_q <= new_word;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_word;
      end
      if (count_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ins       = out_q.ins;
  assign out_err   = out_q.err;
  assign enc_count = cnt_q;

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: scoreboard of expected words pushed on
// accept, compared on output; scenario tasks add directed checks.
module tb_ins_encoder;
  import ins_enc_pkg::*;

  localparam int TB_CNT_W = 4;
`ifdef ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [2:0]          fmt = 3'd0;
  logic [6:0]          opcode = 7'd0;
  logic [4:0]          rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]          funct3 = 3'd0;
  logic [6:0]          funct7 = 7'd0;
  logic [31:0]         imm = 32'd0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [31:0]         ins;
  logic                out_err;
  logic [TB_CNT_W-1:0] enc_count;

  int checks = 0;
  int errors = 0;
  logic [32:0]         exp_q[$];
  logic [TB_CNT_W-1:0] exp_cnt = '0;
  logic                rdy_done;

  ins_encoder #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .ins(ins),
    .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  // Reference encoder: {err, ins}
  function automatic logic [32:0] enc_model(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    logic signed [31:0] si;
    si = im;
    e  = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin w = {im[11:0], s1, f3, d, op}; e = RC && (si > 2047 || si < -2048); end
      3'd2: begin w = {im[11:5], s2, s1, f3, im[4:0], op}; e = RC && (si > 2047 || si < -2048); end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = RC && (im[0] || si > 4095 || si < -4096);
      end
      3'd4: begin w = {im[31:12], d, op}; e = RC && (im[11:0] != 12'd0); end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = RC && (im[0] || si > 1048575 || si < -1048576);
      end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
    return {e, w};
  endfunction

  // Samples at negedge: handshakes seen here complete on the next rising edge.
  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got err=%b ins=%h, required no word outstanding", out_err, ins);
          end else begin
            e = exp_q[0];
            if ({out_err, ins} !== e) begin
              errors++;
              $display("FAIL out_word: got err=%b ins=%h, required err=%b ins=%h", out_err, ins, e[32], e[31:0]);
            end
            if (out_ready) begin
              e = exp_q.pop_front();
              $display("xfer out: ins=%h err=%b", ins, out_err);
            end
          end
          if (out_ready) exp_cnt = exp_cnt + 1'b1;
        end
        if (in_valid && in_ready)
          exp_q.push_back(enc_model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
      end
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    logic ok;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drive_timeout: got in_ready=0 for 64 cycles, required accept");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({out_valid, out_err, ins, enc_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b err=%b ins=%h cnt=%0d, required all 0", out_valid, out_err, ins, enc_count);
    end
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_i_format();
    out_ready = 1'b1;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++;
    if (out_valid !== 1'b1 || ins !== 32'h0050_0093 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL i_addi: got valid=%b ins=%h err=%b, required 1 00500093 0", out_valid, ins, out_err);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [TB_CNT_W-1:0] c0;
    out_ready = 1'b1;
    c0 = enc_count;
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    checks++;
    if (ins !== 32'h0020_A423) begin
      errors++; $display("FAIL s_sw: got ins=%h, required 0020a423", ins);
    end
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
    checks++;
    if (ins !== 32'h0020_81B3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL r_add: got ins=%h valid=%b, required 002081b3 1", ins, out_valid);
    end
    idle(1);
    checks++;
    if (enc_count !== c0 + 2'd2) begin
      errors++; $display("FAIL b2b_count: got %0d, required %0d", enc_count, c0 + 2'd2);
    end
    idle(1);
  endtask

  task automatic test_bju();
    out_ready = 1'b1;
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    checks++;
    if (ins !== 32'hFE00_0EE3 || out_err !== 1'b0) begin
      errors++; $display("FAIL b_beq: got ins=%h err=%b, required fe000ee3 0", ins, out_err);
    end
    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    checks++;
    if (ins !== 32'h0080_00EF || out_err !== 1'b0) begin
      errors++; $display("FAIL j_jal: got ins=%h err=%b, required 008000ef 0", ins, out_err);
    end
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    checks++;
    if (ins !== 32'h1234_52B7 || out_err !== 1'b0) begin
      errors++; $display("FAIL u_lui: got ins=%h err=%b, required 123452b7 0", ins, out_err);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_one: got in_ready=%b valid=%b, required 1 1", in_ready, out_valid);
    end
    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got in_ready=%b, required 0", in_ready);
    end
    fmt = 3'd4; opcode = 7'h37; rd = 5'd5; imm = 32'h1234_5000;
    in_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      idle(1);
      checks++;
      if (in_ready !== 1'b0 || ins !== 32'h0050_0093) begin
        errors++; $display("FAIL bp_hold: got in_ready=%b ins=%h, required 0 00500093", in_ready, ins);
      end
    end
    out_ready = 1'b1;
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    idle(3);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || enc_count !== exp_cnt) begin
      errors++;
      $display("FAIL bp_drain: got pending=%0d valid=%b cnt=%0d, required 0 0 %0d", exp_q.size(), out_valid, enc_count, exp_cnt);
    end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    drive(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checks++;
    if (ins !== 32'h0000_0013 || out_err !== 1'b1) begin
      errors++; $display("FAIL err_fmt7: got ins=%h err=%b, required 00000013 1", ins, out_err);
    end
    drive(3'd6, 7'h13, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checks++;
    if (ins !== 32'h0000_0013 || out_err !== 1'b1) begin
      errors++; $display("FAIL err_fmt6: got ins=%h err=%b, required 00000013 1", ins, out_err);
    end
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    checks++;
    if (out_err !== RC) begin
      errors++; $display("FAIL err_b_odd: got err=%b, required %b", out_err, RC);
    end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    checks++;
    if (out_err !== RC || ins !== 32'h8000_0093) begin
      errors++; $display("FAIL err_i_2048: got err=%b ins=%h, required %b 80000093", out_err, ins, RC);
    end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    checks++;
    if (out_err !== 1'b0) begin
      errors++; $display("FAIL err_i_min: got err=%b, required 0", out_err);
    end
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    checks++;
    if (out_err !== RC) begin
      errors++; $display("FAIL err_u_low: got err=%b, required %b", out_err, RC);
    end
    idle(2);
  endtask

  task automatic test_random();
    rdy_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), $urandom);
        rdy_done = 1'b1;
      end
      begin
        while (!rdy_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (exp_q.size() != 0 || enc_count !== exp_cnt) begin
      errors++;
      $display("FAIL rand_drain: got pending=%0d cnt=%0d, required 0 %0d", exp_q.size(), enc_count, exp_cnt);
    end
  endtask

  task automatic test_count_wrap();
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      drive(3'd0, 7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      idle(1);
      checks++;
      if (enc_count !== exp_cnt) begin
        errors++; $display("FAIL cnt_wrap: got %0d, required %0d", enc_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || enc_count !== '0 || ins !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: got valid=%b cnt=%0d ins=%h, required 0 0 0", out_valid, enc_count, ins);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release: got in_ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    idle(2);
    checks++;
    if (enc_count !== 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_after: got cnt=%0d pending=%0d, required 1 0", enc_count, exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_i_format();
    test_back_to_back();
    test_bju();
    test_backpressure();
    test_errors();
    test_count_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
